// File: rtl/camera_tx.sv
// OV7670-style byte-serial camera transmitter: vsync/href framing with RGB565 pixels sent high byte first.
// Optional CAMERA_TX_TEST_PATTERN_EN adds pattern_en to source a synthetic {line,col,line} pattern.
module camera_tx #(
    parameter int H_ACTIVE    = 640,
    parameter int H_BLANK     = 144,
    parameter int V_ACTIVE    = 480,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic        p_clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] pixel_data,
    input  logic        pixel_valid,
`ifdef CAMERA_TX_TEST_PATTERN_EN
    input  logic        pattern_en,
`endif
    output logic        pixel_ready,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  p_data,
    output logic        frame_start,
    output logic        frame_done,
    output logic        underrun
);

    localparam int L      = 2 * H_ACTIVE + H_BLANK;
    localparam int VMAX_A = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
    localparam int VMAX_B = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int VMAX   = (VMAX_A > VMAX_B) ? VMAX_A : VMAX_B;
    localparam int HW     = (L > 1) ? $clog2(L) : 1;
    localparam int VW     = (VMAX > 1) ? $clog2(VMAX) : 1;

    localparam logic [HW-1:0] H_LINE_END  = HW'(L - 1);
    localparam logic [HW-1:0] H_ACT_END   = HW'(2 * H_ACTIVE - 1);
    localparam logic [HW-1:0] H_BLK_END   = HW'(H_BLANK - 1);
    localparam logic [VW-1:0] V_SYNC_END  = VW'(VSYNC_LINES - 1);
    localparam logic [VW-1:0] V_BACK_END  = VW'(V_BACK - 1);
    localparam logic [VW-1:0] V_ACT_END   = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] V_FRONT_END = VW'(V_FRONT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_VSYNC  = 3'd1;
    localparam logic [2:0] S_VBACK  = 3'd2;
    localparam logic [2:0] S_ACTIVE = 3'd3;
    localparam logic [2:0] S_HBLANK = 3'd4;
    localparam logic [2:0] S_VFRONT = 3'd5;

    logic [2:0]    state, state_n;
    logic [HW-1:0] hcnt, hcnt_n;
    logic [VW-1:0] vcnt, vcnt_n;
    logic          line_end;
    logic          load, load_n, ready_n;
    logic          enter_frame;
    logic [7:0]    lo_byte;
    logic [15:0]   pix_word;

    always_comb begin
        state_n  = state;
        hcnt_n   = hcnt + 1'b1;
        vcnt_n   = vcnt;
        line_end = (hcnt == H_LINE_END);
        case (state)
            S_IDLE: begin
                hcnt_n = '0;
                vcnt_n = '0;
                if (enable) state_n = S_VSYNC;
            end
            S_VSYNC: if (line_end) begin
                hcnt_n = '0;
                if (vcnt == V_SYNC_END) begin
                    vcnt_n  = '0;
                    state_n = S_VBACK;
                end else vcnt_n = vcnt + 1'b1;
            end
            S_VBACK: if (line_end) begin
                hcnt_n = '0;
                if (vcnt == V_BACK_END) begin
                    vcnt_n  = '0;
                    state_n = S_ACTIVE;
                end else vcnt_n = vcnt + 1'b1;
            end
            S_ACTIVE: if (hcnt == H_ACT_END) begin
                hcnt_n  = '0;
                state_n = S_HBLANK;
            end
            S_HBLANK: if (hcnt == H_BLK_END) begin
                hcnt_n = '0;
                if (vcnt == V_ACT_END) begin
                    vcnt_n  = '0;
                    state_n = S_VFRONT;
                end else begin
                    vcnt_n  = vcnt + 1'b1;
                    state_n = S_ACTIVE;
                end
            end
            S_VFRONT: if (line_end) begin
                hcnt_n = '0;
                if (vcnt == V_FRONT_END) begin
                    vcnt_n  = '0;
                    state_n = enable ? S_VSYNC : S_IDLE;
                end else vcnt_n = vcnt + 1'b1;
            end
            default: begin
                state_n = S_IDLE;
                hcnt_n  = '0;
                vcnt_n  = '0;
            end
        endcase
    end

    // Outputs are registered from the next-state values, so a strobe that must be high
    // in the cycle before an even ACTIVE cycle looks one step further ahead than state_n.
    always_comb begin
        enter_frame = (state_n == S_VSYNC) && (state != S_VSYNC);
        load_n = ((state_n == S_ACTIVE) && hcnt_n[0] && (hcnt_n != H_ACT_END)) ||
                 ((state_n == S_VBACK) && (hcnt_n == H_LINE_END) && (vcnt_n == V_BACK_END)) ||
                 ((state_n == S_HBLANK) && (hcnt_n == H_BLK_END) && (vcnt_n != V_ACT_END));
        ready_n = load_n;
    end

`ifdef CAMERA_TX_TEST_PATTERN_EN
    logic       pattern_mode, pattern_mode_n;
    logic [5:0] pat_col;
    logic [4:0] pat_line;

    always_comb begin
        pattern_mode_n = enter_frame ? pattern_en : pattern_mode;
        if (pattern_mode_n) ready_n = 1'b0;
    end

    always_comb begin
        pat_col  = (state == S_ACTIVE) ? 6'((hcnt + 1'b1) >> 1) : '0;
        pat_line = (state == S_ACTIVE) ? 5'(vcnt) :
                   (state == S_HBLANK) ? 5'(vcnt + 1'b1) : '0;
        pix_word = pixel_valid ? pixel_data : '0;
        if (pattern_mode) pix_word = {pat_line, pat_col, pat_line};
    end

    always_ff @(posedge p_clock) begin
        if (reset) pattern_mode <= 1'b0;
        else       pattern_mode <= pattern_mode_n;
    end
`else
    always_comb begin
        pix_word = pixel_valid ? pixel_data : '0;
    end
`endif

    always_ff @(posedge p_clock) begin
        if (reset) begin
            state       <= S_IDLE;
            hcnt        <= '0;
            vcnt        <= '0;
            vsync       <= 1'b0;
            href        <= 1'b0;
            p_data      <= '0;
            lo_byte     <= '0;
            load        <= 1'b0;
            pixel_ready <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            state       <= state_n;
            hcnt        <= hcnt_n;
            vcnt        <= vcnt_n;
            vsync       <= (state_n == S_VSYNC);
            href        <= (state_n == S_ACTIVE);
            frame_start <= enter_frame;
            frame_done  <= (state_n == S_VFRONT) && (hcnt_n == H_LINE_END) &&
                           (vcnt_n == V_FRONT_END);
            load        <= load_n;
            pixel_ready <= ready_n;
            if (load) begin
                p_data  <= pix_word[15:8];
                lo_byte <= pix_word[7:0];
            end else if (state_n == S_ACTIVE) begin
                p_data  <= lo_byte;
            end else begin
                p_data  <= '0;
            end
            if (pixel_ready && !pixel_valid) underrun <= 1'b1;
        end
    end

endmodule
